// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : motor_pkg
//  Purpose  : Types and defaults shared by the motor control blocks
//             (motion sequencer, PWM generator, encoder decoder).
//  Contents : motor_state_t - sequencer state encoding (3 bits)
//             DUTY_W_DEF / POS_W_DEF - default duty and position widths
//             is_motion() - true for the states that actively drive the bridge
//  Revision : 1.0 - initial release
// ============================================================================
package motor_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int POS_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEAD   = 3'd1,
    ST_ACCEL  = 3'd2,
    ST_CRUISE = 3'd3,
    ST_DECEL  = 3'd4,
    ST_FAULT  = 3'd5
  } motor_state_t;

  function automatic logic is_motion(input motor_state_t s);
    return (s != ST_IDLE) && (s != ST_FAULT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/motion_ramp_tick.sv
`default_nettype none
// ============================================================================
//  Module   : motion_ramp_tick
//  Purpose  : Ramp prescaler. Counts 0..RAMP_DIV-1 and emits a one-clock
//             tick on the wrap cycle. A synchronous clear restarts the
//             count and masks the tick in the same cycle.
//  Ports    : i_clk   - system clock
//             i_rst_n - asynchronous active-low reset
//             i_clr   - synchronous restart of the prescaler
//             o_tick  - one-clock ramp tick
//  Revision : 1.0 - initial release
// ============================================================================
module motion_ramp_tick #(
  parameter int RAMP_DIV = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int                c_cnt_w = $clog2(RAMP_DIV);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(RAMP_DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == c_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == c_last) && !i_clr;

endmodule
`default_nettype wire

// File: rtl/motor_motion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : motor_motion_sequencer
//  Purpose  : Closed-loop move sequencer between the register file and the
//             PWM/H-bridge datapath: trapezoidal duty ramp, dead-time on
//             reversal, overshoot correction and stall fault.
//  Ports    : i_clk, i_rst_n (async, active-low)
//             i_enable        - 0 aborts motion and holds IDLE
//             i_cmd_valid / o_cmd_ready, i_cmd_target, i_cmd_max_duty
//             i_enc_count, i_enc_step - quadrature decoder position / edge pulse
//             i_clear_fault   - leaves FAULT
//             o_duty, o_dir, o_brake - registered bridge drive
//             o_busy, o_done, o_stall_fault - status
//  Revision : 1.0 - initial release
// ============================================================================
module motor_motion_sequencer
  import motor_pkg::*;
#(
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int POS_W     = POS_W_DEF,
  parameter int RAMP_DIV  = 256,
  parameter int RAMP_STEP = 4,
  parameter int MIN_DUTY  = 16,
  parameter int DECEL_WIN = 64,
  parameter int TOL       = 2,
  parameter int DEADTIME  = 32,
  parameter int STALL_CYC = 65535
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [POS_W-1:0]  i_cmd_target,
  input  logic [DUTY_W-1:0] i_cmd_max_duty,
  input  logic [POS_W-1:0]  i_enc_count,
  input  logic              i_enc_step,
  input  logic              i_clear_fault,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_dir,
  output logic              o_brake,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_stall_fault
);

  localparam int                  c_dead_w     = $clog2(DEADTIME + 1);
  localparam logic [c_dead_w-1:0] c_dead_last  = c_dead_w'(DEADTIME - 1);
  localparam int                  c_stall_w    = $clog2(STALL_CYC + 1);
  localparam logic [c_stall_w-1:0] c_stall_last = c_stall_w'(STALL_CYC - 1);
  localparam logic [POS_W:0]      c_tol        = (POS_W+1)'(TOL);
  localparam logic [POS_W:0]      c_decel_win  = (POS_W+1)'(DECEL_WIN);
  localparam logic [DUTY_W:0]     c_step       = (DUTY_W+1)'(RAMP_STEP);
  localparam logic [DUTY_W:0]     c_dn_floor   = (DUTY_W+1)'(MIN_DUTY + RAMP_STEP);
  localparam logic [DUTY_W-1:0]   c_min        = DUTY_W'(MIN_DUTY);

  motor_state_t          r_state;
  motor_state_t          r_state_d;
  logic [POS_W-1:0]      r_target;
  logic [DUTY_W-1:0]     r_max_duty;
  logic                  r_pending;
  logic [c_dead_w-1:0]   r_dead_cnt;
  logic [c_stall_w-1:0]  r_stall_cnt;
  logic [DUTY_W-1:0]     r_duty;
  logic                  r_dir;
  logic                  r_brake;
  logic                  r_done;

  logic [POS_W:0]        w_err;
  logic [POS_W:0]        w_aerr;
  logic                  w_want_dir;
  logic                  w_cmd_ready;
  logic                  w_cmd_acc;
  logic                  w_stall;
  logic                  w_tick;
  logic                  w_ramp_clr;
  logic [DUTY_W:0]       w_duty_up;
  logic [DUTY_W-1:0]     w_duty_acc;
  logic [DUTY_W-1:0]     w_duty_dec;

  // Sign-extended one bit so target - position never wraps.
  assign w_err      = {r_target[POS_W-1], r_target} - {i_enc_count[POS_W-1], i_enc_count};
  assign w_aerr     = w_err[POS_W] ? (~w_err + 1'b1) : w_err;
  assign w_want_dir = !w_err[POS_W] && (w_err != '0);

  assign w_cmd_ready = (r_state == ST_IDLE) && i_enable;
  assign w_cmd_acc   = i_cmd_valid && w_cmd_ready;

  // Fires on the clock the counter would reach STALL_CYC.
  assign w_stall = (r_stall_cnt == c_stall_last) && !i_enc_step && (r_duty != '0);

  // Ramp saturates at the move ceiling going up and clamps at the floor going down.
  assign w_duty_up  = {1'b0, r_duty} + c_step;
  assign w_duty_acc = (w_duty_up >= {1'b0, r_max_duty}) ? r_max_duty : w_duty_up[DUTY_W-1:0];
  assign w_duty_dec = ({1'b0, r_duty} <= c_dn_floor) ? c_min : (r_duty - c_step[DUTY_W-1:0]);

  // Prescaler restarts on every state entry.
  assign w_ramp_clr = (r_state != r_state_d);

  motion_ramp_tick #(
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_ramp_clr),
    .o_tick  (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_enc_step || (r_duty == '0)) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_state_d  <= ST_IDLE;
      r_target   <= '0;
      r_max_duty <= '0;
      r_pending  <= 1'b0;
      r_dead_cnt <= '0;
      r_duty     <= '0;
      r_dir      <= 1'b0;
      r_brake    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state_d <= r_state;
      r_done    <= 1'b0;
      if (!i_enable && (r_state != ST_FAULT)) begin
        r_state   <= ST_IDLE;
        r_duty    <= '0;
        r_brake   <= 1'b1;
        r_pending <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cmd_acc) begin
              r_target   <= i_cmd_target;
              r_max_duty <= i_cmd_max_duty;
              r_pending  <= 1'b1;
            end else if (r_pending) begin
              // Latched target is evaluated the clock after acceptance.
              r_pending <= 1'b0;
              if (w_aerr <= c_tol) begin
                r_done <= 1'b1;
              end else if (w_want_dir != r_dir) begin
                r_state    <= ST_DEAD;
                r_dead_cnt <= '0;
                r_brake    <= 1'b0;
              end else begin
                r_state <= ST_ACCEL;
                r_brake <= 1'b0;
              end
            end
          end
          ST_DEAD: begin
            if (r_dead_cnt == c_dead_last) begin
              r_dir   <= w_want_dir;
              r_state <= ST_ACCEL;
            end else begin
              r_dead_cnt <= r_dead_cnt + 1'b1;
            end
          end
          ST_ACCEL, ST_CRUISE, ST_DECEL: begin
            if (w_stall) begin
              r_state <= ST_FAULT;
              r_duty  <= '0;
              r_brake <= 1'b1;
            end else if (w_aerr <= c_tol) begin
              r_state <= ST_IDLE;
              r_duty  <= '0;
              r_brake <= 1'b1;
              r_done  <= 1'b1;
            end else if (w_want_dir != r_dir) begin
              // Overshoot: cut drive immediately and reverse through dead-time.
              r_state    <= ST_DEAD;
              r_duty     <= '0;
              r_dead_cnt <= '0;
            end else if ((r_state != ST_DECEL) && (w_aerr <= c_decel_win)) begin
              r_state <= ST_DECEL;
            end else if (r_state == ST_ACCEL) begin
              if (r_duty == r_max_duty) begin
                r_state <= ST_CRUISE;
              end else if (w_tick) begin
                r_duty <= w_duty_acc;
              end
            end else if ((r_state == ST_DECEL) && w_tick) begin
              r_duty <= w_duty_dec;
            end
          end
          ST_FAULT: begin
            if (i_clear_fault) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_duty  <= '0;
            r_brake <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_cmd_ready   = w_cmd_ready;
  assign o_duty        = r_duty;
  assign o_dir         = r_dir;
  assign o_brake       = r_brake;
  assign o_done        = r_done;
  assign o_busy        = is_motion(r_state);
  assign o_stall_fault = (r_state == ST_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_motor_motion_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_motor_motion_sequencer
//  Purpose  : Directed self-checking bench for motor_motion_sequencer with a
//             simple encoder model (one count per 8 clocks while duty > 0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_motor_motion_sequencer;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_enable;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [15:0] i_cmd_target;
  logic [7:0]  i_cmd_max_duty;
  logic [15:0] i_enc_count;
  logic        i_enc_step;
  logic        i_clear_fault;
  logic [7:0]  o_duty;
  logic        o_dir;
  logic        o_brake;
  logic        o_busy;
  logic        o_done;
  logic        o_stall_fault;

  int n_pass  = 0;
  int n_total = 0;
  int enc_div = 0;
  logic enc_auto = 1'b0;

  always #5 clk = ~clk;

  motor_motion_sequencer dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_target   (i_cmd_target),
    .i_cmd_max_duty (i_cmd_max_duty),
    .i_enc_count    (i_enc_count),
    .i_enc_step     (i_enc_step),
    .i_clear_fault  (i_clear_fault),
    .o_duty         (o_duty),
    .o_dir          (o_dir),
    .o_brake        (o_brake),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_stall_fault  (o_stall_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance to the next falling edge and run the encoder model there.
  task automatic cyc();
    @(negedge clk);
    i_enc_step = 1'b0;
    if (enc_auto && (o_duty != 8'd0)) begin
      enc_div++;
      if (enc_div == 8) begin
        enc_div     = 0;
        i_enc_count = o_dir ? (i_enc_count + 16'd1) : (i_enc_count - 16'd1);
        i_enc_step  = 1'b1;
      end
    end
  endtask

  task automatic issue(input logic [15:0] tgt, input logic [7:0] mx);
    i_cmd_target   = tgt;
    i_cmd_max_duty = mx;
    i_cmd_valid    = 1'b1;
    cyc();
    i_cmd_valid    = 1'b0;
  endtask

  initial begin
    int n;
    int peak;
    int last_nz;

    i_rst_n = 1'b0; i_enable = 1'b1; i_cmd_valid = 1'b0; i_cmd_target = '0;
    i_cmd_max_duty = '0; i_enc_count = '0; i_enc_step = 1'b0; i_clear_fault = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) cyc();
    chk("rst_duty", o_duty, 0);
    chk("rst_dir", o_dir, 0);
    chk("rst_brake", o_brake, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_stall", o_stall_fault, 0);
    chk("rst_ready", o_cmd_ready, 1);
    i_rst_n = 1'b1;
    cyc();

    // ---------------- full move 0 -> 500, max 200 ----------------
    i_enc_count = 16'd0; enc_auto = 1'b1; enc_div = 0;
    issue(16'd500, 8'd200);
    chk("m1_pending_not_busy", o_busy, 0);
    cyc();
    chk("m1_dead_brake", o_brake, 0);
    n = 0;
    while (o_busy && !o_dir && (o_duty == 8'd0) && n < 100) begin n++; cyc(); end
    chk("m1_dead_len", n, 32);
    chk("m1_dir_pos", o_dir, 1);
    n = 0;
    while ((o_duty == 8'd0) && n < 1000) begin n++; cyc(); end
    chk("m1_first_tick_delay", n, 257);
    chk("m1_first_step", o_duty, 4);
    n = 0;
    while ((o_duty == 8'd4) && n < 1000) begin n++; cyc(); end
    chk("m1_tick_period", n, 256);
    chk("m1_second_step", o_duty, 8);
    peak = 0; last_nz = 0; n = 0;
    while (!o_done && n < 8000) begin
      if (o_duty > peak) peak = o_duty;
      if (o_duty != 8'd0) last_nz = o_duty;
      n++; cyc();
    end
    chk("m1_done_seen", o_done, 1);
    chk("m1_peak_duty", peak, 56);
    chk("m1_decel_step", last_nz, 52);
    chk("m1_done_pos", i_enc_count, 498);
    chk("m1_done_duty", o_duty, 0);
    chk("m1_done_brake", o_brake, 1);
    chk("m1_done_busy", o_busy, 0);
    cyc();
    chk("m1_done_pulse", o_done, 0);

    // ---------------- already within tolerance ----------------
    issue(16'd499, 8'd200);
    chk("tol_done_early", o_done, 0);
    cyc();
    chk("tol_done", o_done, 1);
    chk("tol_duty", o_duty, 0);
    chk("tol_busy", o_busy, 0);
    cyc();
    chk("tol_done_pulse", o_done, 0);
    chk("tol_stay_idle", o_busy, 0);

    // ---------------- reversal then abort in CRUISE ----------------
    issue(16'd100, 8'd8);
    cyc();
    n = 0;
    while (o_busy && o_dir && (o_duty == 8'd0) && n < 100) begin n++; cyc(); end
    chk("rev_dead_len", n, 32);
    chk("rev_dir_neg", o_dir, 0);
    chk("rev_busy", o_busy, 1);
    n = 0;
    while ((o_duty == 8'd0) && n < 1000) begin n++; cyc(); end
    chk("rev_first_tick_delay", n, 257);
    n = 0;
    while ((o_duty == 8'd4) && n < 1000) begin n++; cyc(); end
    chk("rev_reach_max", o_duty, 8);
    repeat (300) cyc();
    chk("cruise_hold", o_duty, 8);
    chk("cruise_enc_moved_down", (i_enc_count < 16'd498), 1);
    i_enable = 1'b0;
    cyc();
    chk("abort_duty", o_duty, 0);
    chk("abort_brake", o_brake, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_no_done", o_done, 0);
    chk("abort_ready", o_cmd_ready, 0);
    i_enable = 1'b1;
    cyc();
    chk("abort_ready_back", o_cmd_ready, 1);
    chk("abort_discarded", o_busy, 0);

    // ---------------- overshoot correction ----------------
    enc_auto = 1'b0; i_enc_count = 16'd1000;
    issue(16'd900, 8'd8);
    cyc();
    chk("os_accel_direct", o_busy, 1);
    chk("os_accel_brake", o_brake, 0);
    n = 0;
    while ((o_duty == 8'd0) && n < 1000) begin n++; cyc(); end
    chk("os_first_step", o_duty, 4);
    i_enc_count = 16'd890; enc_div = 0; enc_auto = 1'b1;
    cyc();
    chk("os_duty_cut", o_duty, 0);
    chk("os_busy", o_busy, 1);
    n = 0;
    while (o_busy && !o_dir && (o_duty == 8'd0) && n < 100) begin n++; cyc(); end
    chk("os_dead_len", n, 32);
    chk("os_dir_rev", o_dir, 1);
    n = 0;
    while ((o_duty == 8'd0) && n < 1000) begin n++; cyc(); end
    chk("os_decel_delay", n, 258);
    chk("os_decel_floor", o_duty, 16);
    n = 0;
    while (!o_done && n < 500) begin n++; cyc(); end
    chk("os_done", o_done, 1);
    chk("os_done_pos", i_enc_count, 898);
    chk("os_done_duty", o_duty, 0);

    // ---------------- stall fault ----------------
    enc_auto = 1'b0; i_enc_count = 16'd0;
    issue(16'd5000, 8'd200);
    cyc();
    n = 0;
    while (!o_stall_fault && n < 70000) begin
      if (o_duty != 8'd0) n++;
      cyc();
    end
    chk("stall_run_len", n, 65535);
    chk("stall_flag", o_stall_fault, 1);
    chk("stall_duty", o_duty, 0);
    chk("stall_brake", o_brake, 1);
    chk("stall_busy", o_busy, 0);
    chk("stall_ready", o_cmd_ready, 0);
    i_cmd_valid = 1'b1;
    cyc();
    chk("fault_ignores_cmd", o_stall_fault, 1);
    i_clear_fault = 1'b1;
    cyc();
    chk("fault_cleared", o_stall_fault, 0);
    i_clear_fault = 1'b0; i_cmd_valid = 1'b0;
    cyc();
    cyc();
    chk("clear_cmd_not_taken", o_busy, 0);
    chk("clear_ready", o_cmd_ready, 1);

    // ---------------- async reset mid-move ----------------
    i_enc_count = 16'd0;
    issue(16'd5000, 8'd200);
    repeat (300) cyc();
    chk("ar_moving", o_duty, 4);
    #2 i_rst_n = 1'b0;
    #1;
    chk("ar_duty", o_duty, 0);
    chk("ar_brake", o_brake, 1);
    chk("ar_dir", o_dir, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_done", o_done, 0);
    cyc();
    i_rst_n = 1'b1;
    cyc();
    chk("ar_idle_after", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
